// File: rtl/neander_x_mbseq.sv
// Multi-byte add/subtract sequencer that drives an external 8-bit ALU one byte at a time, LSB first.
// Optional abort input is enabled by defining NEANDER_X_MBSEQ_ABORT_EN.
module neander_x_mbseq (
   input  logic       clk,
   input  logic       rst_n,
`ifdef NEANDER_X_MBSEQ_ABORT_EN
   input  logic       abort,
`endif
   input  logic       start,
   input  logic       op_sel,
   input  logic [2:0] len,
   input  logic       in_valid,
   input  logic [7:0] in_a,
   input  logic [7:0] in_b,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   input  logic       out_ready,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_op,
   output logic       alu_carry_in,
   input  logic [7:0] alu_result,
   input  logic       alu_carry,
   output logic       busy,
   output logic       done,
   output logic       carry_final,
   output logic       zero_final
);

   typedef enum logic [2:0] {IDLE, FETCH, EXEC, EMIT, DONE} state_t;

   state_t     state;
   state_t     state_next;
   logic       op_reg;
   logic [2:0] len_reg;
   logic [3:0] byte_cnt;
   logic [3:0] byte_total;
   logic       last_byte;
   logic       carry_reg;
   logic       zero_acc;
   logic [7:0] a_reg;
   logic [7:0] b_reg;
   logic [7:0] out_data_reg;
   logic       abort_hit;

`ifdef NEANDER_X_MBSEQ_ABORT_EN
   assign abort_hit = abort && (state != IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   // A latched length of zero stands for a full 8-byte chain.
   assign byte_total = (len_reg == 3'd0) ? 4'd8 : {1'b0, len_reg};
   assign last_byte  = ((byte_cnt + 4'd1) == byte_total);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = FETCH;
         FETCH:   if (in_valid) state_next = EXEC;
         EXEC:    state_next = EMIT;
         EMIT:    if (out_ready) state_next = last_byte ? DONE : FETCH;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (abort_hit) begin
         state_next = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_reg       <= 1'b0;
         len_reg      <= 3'd0;
         byte_cnt     <= 4'd0;
         carry_reg    <= 1'b0;
         zero_acc     <= 1'b0;
         a_reg        <= 8'h00;
         b_reg        <= 8'h00;
         out_data_reg <= 8'h00;
         carry_final  <= 1'b0;
         zero_final   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_reg    <= op_sel;
                  len_reg   <= len;
                  byte_cnt  <= 4'd0;
                  carry_reg <= 1'b0;
                  zero_acc  <= 1'b1;
               end
            end
            FETCH: begin
               if (in_valid && !abort_hit) begin
                  a_reg <= in_a;
                  b_reg <= in_b;
               end
            end
            EXEC: begin
               out_data_reg <= alu_result;
               carry_reg    <= alu_carry;
               zero_acc     <= zero_acc & (alu_result == 8'h00);
            end
            EMIT: begin
               if (out_ready && !abort_hit) begin
                  byte_cnt <= byte_cnt + 4'd1;
               end
            end
            DONE: begin
               if (!abort_hit) begin
                  carry_final <= carry_reg;
                  zero_final  <= zero_acc;
               end
            end
            default: ;
         endcase
      end
   end

   // The first byte uses plain ADD/SUB; later bytes chain the carry through ADC/SBC.
   always_comb begin
      in_ready     = (state == FETCH);
      out_valid    = (state == EMIT);
      busy         = (state != IDLE);
      done         = (state == DONE) && !abort_hit;
      out_data     = out_data_reg;
      alu_a        = 8'h00;
      alu_b        = 8'h00;
      alu_op       = 4'b0000;
      alu_carry_in = 1'b0;
      if (state == EXEC) begin
         alu_a        = a_reg;
         alu_b        = b_reg;
         alu_carry_in = carry_reg;
         alu_op       = (byte_cnt == 4'd0) ? {3'b000, op_reg} : {3'b110, op_reg};
      end
   end

endmodule

// File: tb/tb_neander_x_mbseq.sv
// Scoreboard bench for neander_x_mbseq: a behavioural ALU answers the DUT, a monitor checks bytes, opcodes and finals.
// Abort scenario is included when NEANDER_X_MBSEQ_ABORT_EN is defined.
module tb_neander_x_mbseq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, op_sel, in_valid, out_ready;
   logic [2:0] len;
   logic [7:0] in_a, in_b;
   logic       in_ready, out_valid, busy, done, carry_final, zero_final;
   logic [7:0] out_data, alu_a, alu_b, alu_result;
   logic [3:0] alu_op;
   logic       alu_carry_in, alu_carry;
`ifdef NEANDER_X_MBSEQ_ABORT_EN
   logic       abort;
`endif

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int cyc = 0;
   int last_exec_cyc = -1;
   logic lat_check = 1'b0;
   logic fin_pending = 1'b0;

   logic [7:0] exp_data [$];
   logic [4:0] exp_op   [$];
   logic [1:0] exp_fin  [$];
   logic [7:0] stim_a [8];
   logic [7:0] stim_b [8];

   neander_x_mbseq dut (
      .clk(clk), .rst_n(rst_n),
`ifdef NEANDER_X_MBSEQ_ABORT_EN
      .abort(abort),
`endif
      .start(start), .op_sel(op_sel), .len(len),
      .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_carry_in(alu_carry_in),
      .alu_result(alu_result), .alu_carry(alu_carry),
      .busy(busy), .done(done), .carry_final(carry_final), .zero_final(zero_final)
   );

   always #5 clk = ~clk;

   // Reference ALU: carry out is a carry for additions and a borrow for subtractions.
   logic [8:0] alu_sum;
   always_comb begin
      alu_sum = 9'd0;
      case (alu_op)
         4'b0000: alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
         4'b0001: alu_sum = {1'b0, alu_a} - {1'b0, alu_b};
         4'b1100: alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry_in};
         4'b1101: alu_sum = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_carry_in};
         default: alu_sum = 9'd0;
      endcase
      alu_result = alu_sum[7:0];
      alu_carry  = alu_sum[8];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic reportTimeout(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: wait bound expired", name);
   endtask

   task automatic waitNeg(input string name, input bit want_ready, output bit ok);
      int t = 0;
      @(negedge clk);
      while ((want_ready ? !in_ready : !out_valid) && t < 50) begin
         t++;
         @(negedge clk);
      end
      ok = (t < 50);
      if (!ok) reportTimeout(name);
   endtask

   // Issues one operation with in_valid held high, then scrambles op_sel/len while busy.
   task automatic applyStimulus(input logic op, input logic [2:0] ln, input int n);
      bit ok;
      int t;
      @(posedge clk); #1;
      start = 1'b1; op_sel = op; len = ln;
      @(posedge clk); #1;
      start = 1'b0; op_sel = ~op; len = ln + 3'd2;
      for (int i = 0; i < n; i++) begin
         in_a = stim_a[i]; in_b = stim_b[i]; in_valid = 1'b1;
         waitNeg("fetch_wait", 1'b1, ok);
         if (!ok) begin
            in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      t = 0;
      @(negedge clk);
      while (busy && t < 80) begin
         t++;
         @(negedge clk);
      end
      if (t >= 80) reportTimeout("op_complete");
   endtask

   // Scoreboard monitor: EXEC is the busy cycle with no handshake signal and no done.
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (!busy) last_exec_cyc = -1;
         if (in_ready) checkOutput("alu_idle", {11'd0, alu_a, alu_b, alu_op, alu_carry_in}, 32'd0);
         if (busy && !in_ready && !out_valid && !done) begin
            if (exp_op.size() == 0) reportTimeout("op_queue_underflow");
            else checkOutput("alu_op_cin", {27'd0, alu_op, alu_carry_in}, {27'd0, exp_op.pop_front()});
            if (lat_check && last_exec_cyc >= 0) checkOutput("byte_latency", cyc - last_exec_cyc, 3);
            last_exec_cyc = cyc;
         end
         if (out_valid) begin
            checkOutput("ready_valid_excl", {31'd0, in_ready}, 32'd0);
            if (out_ready) begin
               if (exp_data.size() == 0) reportTimeout("data_queue_underflow");
               else checkOutput("out_data", {24'd0, out_data}, {24'd0, exp_data.pop_front()});
            end
         end
         if (fin_pending) begin
            fin_pending = 1'b0;
            if (exp_fin.size() == 0) reportTimeout("fin_queue_underflow");
            else checkOutput("carry_zero_final", {30'd0, carry_final, zero_final}, {30'd0, exp_fin.pop_front()});
         end
         if (done) begin
            done_cnt++;
            fin_pending = 1'b1;
         end
      end
   end

   initial begin
      bit ok;
      rst_n = 1'b0; start = 1'b0; op_sel = 1'b0; len = 3'd0;
      in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; out_ready = 1'b1;
`ifdef NEANDER_X_MBSEQ_ABORT_EN
      abort = 1'b0;
`endif
      @(negedge clk);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_handshake", {30'd0, in_ready, out_valid}, 32'd0);
      checkOutput("rst_outs", {23'd0, done, out_data}, 32'd0);
      checkOutput("rst_alu", {11'd0, alu_a, alu_b, alu_op, alu_carry_in}, 32'd0);
      checkOutput("rst_finals", {30'd0, carry_final, zero_final}, 32'h1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Add chain, two bytes: FF+01 carries into 12+00.
      stim_a[0] = 8'hFF; stim_b[0] = 8'h01; stim_a[1] = 8'h12; stim_b[1] = 8'h00;
      exp_data.push_back(8'h00); exp_data.push_back(8'h13);
      exp_op.push_back({4'b0000, 1'b0}); exp_op.push_back({4'b1100, 1'b1});
      exp_fin.push_back(2'b00);
      applyStimulus(1'b0, 3'd2, 2);

      // Subtract chain, two bytes: borrow propagates.
      stim_a[0] = 8'h00; stim_b[0] = 8'h01; stim_a[1] = 8'h00; stim_b[1] = 8'h00;
      exp_data.push_back(8'hFF); exp_data.push_back(8'hFF);
      exp_op.push_back({4'b0001, 1'b0}); exp_op.push_back({4'b1101, 1'b1});
      exp_fin.push_back(2'b10);
      applyStimulus(1'b1, 3'd2, 2);

      // len=0 means eight bytes, all zero.
      for (int i = 0; i < 8; i++) begin
         stim_a[i] = 8'h00; stim_b[i] = 8'h00;
         exp_data.push_back(8'h00);
         exp_op.push_back((i == 0) ? {4'b0000, 1'b0} : {4'b1100, 1'b0});
      end
      exp_fin.push_back(2'b01);
      lat_check = 1'b1;
      applyStimulus(1'b0, 3'd0, 8);
      lat_check = 1'b0;
      checkOutput("done_count_after_len8", done_cnt, 3);

      // Output back-pressure: result held while out_ready is low.
      stim_a[0] = 8'h05; stim_b[0] = 8'h03;
      exp_data.push_back(8'h08); exp_op.push_back({4'b0000, 1'b0}); exp_fin.push_back(2'b00);
      out_ready = 1'b0;
      fork
         applyStimulus(1'b0, 3'd1, 1);
         begin
            waitNeg("emit_wait", 1'b0, ok);
            for (int k = 0; k < 3; k++) begin
               checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
               checkOutput("stall_data", {24'd0, out_data}, 32'h08);
               checkOutput("stall_ready", {31'd0, in_ready}, 32'd0);
               @(negedge clk);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join

      // Reset in EXEC of the second byte, then a fresh operation.
      exp_data.push_back(8'h00); exp_op.push_back({4'b0000, 1'b0});
      @(posedge clk); #1;
      start = 1'b1; op_sel = 1'b0; len = 3'd2;
      @(posedge clk); #1;
      start = 1'b0; in_a = 8'hFF; in_b = 8'h01; in_valid = 1'b1;
      waitNeg("rst_fetch0", 1'b1, ok);
      @(posedge clk); #1;
      in_a = 8'h12; in_b = 8'h00;
      waitNeg("rst_fetch1", 1'b1, ok);
      @(posedge clk); #3;
      rst_n = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
      checkOutput("midrst_done", {31'd0, done}, 32'd0);
      checkOutput("midrst_finals", {30'd0, carry_final, zero_final}, 32'h1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      stim_a[0] = 8'hFF; stim_b[0] = 8'h01;
      exp_data.push_back(8'h00); exp_op.push_back({4'b0000, 1'b0}); exp_fin.push_back(2'b11);
      applyStimulus(1'b0, 3'd1, 1);

`ifdef NEANDER_X_MBSEQ_ABORT_EN
      // Abort while waiting for the second operand pair.
      exp_data.push_back(8'h00); exp_op.push_back({4'b0000, 1'b0});
      @(posedge clk); #1;
      start = 1'b1; op_sel = 1'b0; len = 3'd2;
      @(posedge clk); #1;
      start = 1'b0; in_a = 8'hFF; in_b = 8'h01; in_valid = 1'b1;
      waitNeg("abort_fetch0", 1'b1, ok);
      @(posedge clk); #1;
      in_valid = 1'b0;
      waitNeg("abort_fetch1", 1'b1, ok);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_done", {31'd0, done}, 32'd0);
      checkOutput("abort_finals", {30'd0, carry_final, zero_final}, 32'h3);
      repeat (2) @(negedge clk);
`endif

      repeat (3) @(negedge clk);
      checkOutput("done_count_total", done_cnt, 5);
      checkOutput("data_queue_empty", exp_data.size(), 0);
      checkOutput("op_queue_empty", exp_op.size(), 0);
      checkOutput("fin_queue_empty", exp_fin.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation bound expired");
      $fatal(1, "[TB] timeout");
   end

endmodule
